ttt_game_controller: RTL and testbench

- Sequences a two-player tic-tac-toe game and owns the 9-cell board register.
- Alternates turns, accepts moves via a valid/ready handshake and enforces a per-turn timeout by auto-placing a mark.
- Instantiates the existing winner_detector combinationally on the registered board and latches win/draw results for the display and top-level FSM.

---
 rtl/ttt_game_controller.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_ttt_game_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ttt_game_controller.sv
// -----------------------------------------------------------------------------
// ttt_game_controller
//
// Sequences a two-player tic-tac-toe game and owns the 9-cell board register.
// Turns alternate between player 1 (code 01) and player 2 (code 10). A move is
// offered with move_valid/move_pos and taken while move_ready is high. If a
// turn runs out of time the controller places the mover's mark in the
// lowest-numbered empty cell. After every placed mark one CHECK cycle looks
// for a completed line or a full board on the registered board and latches
// the result.
//
// Parameters:
//   TURN_TIMEOUT  cycles allowed per turn
//   TW            width of the turn timer (must hold TURN_TIMEOUT)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       begin new game (honoured in IDLE / GAME_OVER only)
//   move_valid  player presents a move
//   move_pos    target cell 1..9, row-major, 1 = top-left
//   move_ready  controller accepts moves (TURN state)
//   board       cell k in bits [2k-1:2k-2]; 00 empty, 01 P1, 10 P2
//   turn        player to move (01/10), 00 in IDLE and GAME_OVER
//   timer       remaining cycles in the current turn
//   move_err    one-cycle pulse after a rejected move
//   timeout     one-cycle pulse after an automatic move
//   game_over   game finished
//   winner      winning player code, 00 on draw or while playing
//   draw        board full with no winner
//
// Optional build macro TTT_SCORE_EN adds saturating 4-bit result counters
// score_p1, score_p2 and score_draw, cleared only by rst.
// -----------------------------------------------------------------------------
module ttt_game_controller #(
    parameter int unsigned TURN_TIMEOUT = 32'd750000000,
    parameter int unsigned TW           = 32'd30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          move_valid,
    input  logic [3:0]    move_pos,
    output logic          move_ready,
    output logic [17:0]   board,
    output logic [1:0]    turn,
    output logic [TW-1:0] timer,
    output logic          move_err,
    output logic          timeout,
    output logic          game_over,
    output logic [1:0]    winner,
    output logic          draw
`ifdef TTT_SCORE_EN
    ,
    output logic [3:0]    score_p1,
    output logic [3:0]    score_p2,
    output logic [3:0]    score_draw
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TURN  = 2'd1,
        S_CHECK = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [TW-1:0] TIMER_RELOAD = TW'(TURN_TIMEOUT - 32'd1);

    // Read cell k (1..9); any other index reads as empty.
    function automatic logic [1:0] cell_of(input logic [17:0] b, input int unsigned k);
        logic [1:0] v;
        v = 2'b00;
        for (int unsigned i = 32'd1; i <= 32'd9; i++) begin
            if (i == k) begin
                v = b[(i - 32'd1) * 32'd2 +: 2];
            end
        end
        return v;
    endfunction

    // Return b with cell k (1..9) overwritten by code v.
    function automatic logic [17:0] set_cell(input logic [17:0] b, input int unsigned k,
                                             input logic [1:0] v);
        logic [17:0] r;
        r = b;
        for (int unsigned i = 32'd1; i <= 32'd9; i++) begin
            if (i == k) begin
                r[(i - 32'd1) * 32'd2 +: 2] = v;
            end
        end
        return r;
    endfunction

    // Owner code of a line when all three cells hold the same mark, else 00.
    function automatic logic [1:0] line_owner(input logic [17:0] b, input int unsigned a,
                                              input int unsigned c, input int unsigned d);
        logic [1:0] x;
        x = cell_of(b, a);
        if ((x != 2'b00) && (x == cell_of(b, c)) && (x == cell_of(b, d))) begin
            return x;
        end else begin
            return 2'b00;
        end
    endfunction

    // Winner detection over the eight lines. Only the mover can complete a
    // line, so OR-ing the owners yields a single player code.
    function automatic logic [1:0] winner_detector(input logic [17:0] b);
        return line_owner(b, 32'd1, 32'd2, 32'd3) | line_owner(b, 32'd4, 32'd5, 32'd6)
             | line_owner(b, 32'd7, 32'd8, 32'd9) | line_owner(b, 32'd1, 32'd4, 32'd7)
             | line_owner(b, 32'd2, 32'd5, 32'd8) | line_owner(b, 32'd3, 32'd6, 32'd9)
             | line_owner(b, 32'd1, 32'd5, 32'd9) | line_owner(b, 32'd3, 32'd5, 32'd7);
    endfunction

    // Lowest-numbered empty cell, 0 when the board is full.
    function automatic int unsigned first_empty(input logic [17:0] b);
        int unsigned p;
        p = 32'd0;
        for (int unsigned i = 32'd9; i >= 32'd1; i--) begin
            if (cell_of(b, i) == 2'b00) begin
                p = i;
            end
        end
        return p;
    endfunction

    state_t        state_q, state_d;
    logic [17:0]   board_q, board_d;
    logic [1:0]    turn_q, turn_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          move_ready_q, move_ready_d;
    logic          move_err_q, move_err_d;
    logic          timeout_q, timeout_d;
    logic          game_over_q, game_over_d;
    logic [1:0]    winner_q, winner_d;
    logic          draw_q, draw_d;
`ifdef TTT_SCORE_EN
    logic [3:0]    score_p1_q, score_p1_d;
    logic [3:0]    score_p2_q, score_p2_d;
    logic [3:0]    score_draw_q, score_draw_d;
`endif

    logic       pos_in_range;
    logic       move_ok;
    logic [1:0] win_who;
    logic       board_full;

    // Move legality and result detection on the registered board.
    always_comb begin
        pos_in_range = (move_pos >= 4'd1) && (move_pos <= 4'd9);
        move_ok      = move_valid && pos_in_range
                       && (cell_of(board_q, 32'(move_pos)) == 2'b00);
        win_who      = winner_detector(board_q);
        board_full   = (first_empty(board_q) == 32'd0);
    end

    // Next-state and next-output computation for the game sequencer.
    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        turn_d       = turn_q;
        timer_d      = timer_q;
        move_ready_d = move_ready_q;
        move_err_d   = 1'b0;
        timeout_d    = 1'b0;
        game_over_d  = game_over_q;
        winner_d     = winner_q;
        draw_d       = draw_q;
`ifdef TTT_SCORE_EN
        score_p1_d   = score_p1_q;
        score_p2_d   = score_p2_q;
        score_draw_d = score_draw_q;
`endif
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    board_d      = 18'd0;
                    turn_d       = 2'b01;
                    timer_d      = TIMER_RELOAD;
                    move_ready_d = 1'b1;
                    game_over_d  = 1'b0;
                    winner_d     = 2'b00;
                    draw_d       = 1'b0;
                    state_d      = S_TURN;
                end else begin
                    state_d = state_q;
                end
            end
            S_TURN: begin
                if (move_ok) begin
                    // A legal move wins over an expiring timer; timer freezes.
                    board_d      = set_cell(board_q, 32'(move_pos), turn_q);
                    move_ready_d = 1'b0;
                    state_d      = S_CHECK;
                end else begin
                    move_err_d = move_valid;
                    if (timer_q == {TW{1'b0}}) begin
                        board_d      = set_cell(board_q, first_empty(board_q), turn_q);
                        timeout_d    = 1'b1;
                        move_ready_d = 1'b0;
                        state_d      = S_CHECK;
                    end else begin
                        timer_d = timer_q - TW'(1'b1);
                    end
                end
            end
            S_CHECK: begin
                if ((win_who != 2'b00) || board_full) begin
                    game_over_d  = 1'b1;
                    winner_d     = win_who;
                    draw_d       = (win_who == 2'b00);
                    turn_d       = 2'b00;
                    move_ready_d = 1'b0;
                    state_d      = S_OVER;
`ifdef TTT_SCORE_EN
                    if (win_who == 2'b01) begin
                        score_p1_d = (score_p1_q == 4'd15) ? 4'd15 : score_p1_q + 4'd1;
                    end else if (win_who == 2'b10) begin
                        score_p2_d = (score_p2_q == 4'd15) ? 4'd15 : score_p2_q + 4'd1;
                    end else begin
                        score_draw_d = (score_draw_q == 4'd15) ? 4'd15 : score_draw_q + 4'd1;
                    end
`endif
                end else begin
                    turn_d       = ~turn_q;
                    timer_d      = TIMER_RELOAD;
                    move_ready_d = 1'b1;
                    state_d      = S_TURN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            board_q      <= 18'd0;
            turn_q       <= 2'b00;
            timer_q      <= {TW{1'b0}};
            move_ready_q <= 1'b0;
            move_err_q   <= 1'b0;
            timeout_q    <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 2'b00;
            draw_q       <= 1'b0;
`ifdef TTT_SCORE_EN
            score_p1_q   <= 4'd0;
            score_p2_q   <= 4'd0;
            score_draw_q <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            turn_q       <= turn_d;
            timer_q      <= timer_d;
            move_ready_q <= move_ready_d;
            move_err_q   <= move_err_d;
            timeout_q    <= timeout_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
            draw_q       <= draw_d;
`ifdef TTT_SCORE_EN
            score_p1_q   <= score_p1_d;
            score_p2_q   <= score_p2_d;
            score_draw_q <= score_draw_d;
`endif
        end
    end

    assign move_ready = move_ready_q;
    assign board      = board_q;
    assign turn       = turn_q;
    assign timer      = timer_q;
    assign move_err   = move_err_q;
    assign timeout    = timeout_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;
    assign draw       = draw_q;
`ifdef TTT_SCORE_EN
    assign score_p1   = score_p1_q;
    assign score_p2   = score_p2_q;
    assign score_draw = score_draw_q;
`endif

endmodule

// File: tb/tb_ttt_game_controller.sv
// -----------------------------------------------------------------------------
// Testbench for ttt_game_controller. A game-level reference model (cell array,
// line table, current phase and player) predicts every output after every
// clock edge; directed scenarios add explicit constant checks, then a long
// randomized run exercises legal, illegal, timed-out and restarted games.
// -----------------------------------------------------------------------------
module tb_ttt_game_controller;

    localparam int TT  = 8;
    localparam int TWB = 4;

    logic           clk = 1'b0;
    logic           rst, start, move_valid;
    logic [3:0]     move_pos;
    logic           move_ready, move_err, timeout, game_over, draw;
    logic [17:0]    board;
    logic [1:0]     turn, winner;
    logic [TWB-1:0] timer;
`ifdef TTT_SCORE_EN
    logic [3:0]     score_p1, score_p2, score_draw;
`endif

    ttt_game_controller #(.TURN_TIMEOUT(TT), .TW(TWB)) dut (
        .clk(clk), .rst(rst), .start(start), .move_valid(move_valid),
        .move_pos(move_pos), .move_ready(move_ready), .board(board),
        .turn(turn), .timer(timer), .move_err(move_err), .timeout(timeout),
        .game_over(game_over), .winner(winner), .draw(draw)
`ifdef TTT_SCORE_EN
        , .score_p1(score_p1), .score_p2(score_p2), .score_draw(score_draw)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: phase 0 idle, 1 waiting for a move, 2 judging, 3 finished.
    int m_cell [1:9];
    int m_phase, m_player, m_timer, m_win;
    bit m_err, m_to, m_over, m_draw;
    int lines [0:7][0:2] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                             '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_new_game();
        for (int k = 1; k <= 9; k++) m_cell[k] = 0;
        m_over = 0; m_win = 0; m_draw = 0;
        m_player = 1; m_timer = TT - 1; m_phase = 1;
    endtask

    task automatic model_edge(input bit r, input bit s, input bit v, input int p);
        bit ok, full;
        int w;
        if (r) begin
            for (int k = 1; k <= 9; k++) m_cell[k] = 0;
            m_phase = 0; m_player = 0; m_timer = 0; m_win = 0;
            m_err = 0; m_to = 0; m_over = 0; m_draw = 0;
        end else begin
            m_err = 0; m_to = 0;
            if (m_phase == 0 || m_phase == 3) begin
                if (s) model_new_game();
            end else if (m_phase == 1) begin
                ok = 0;
                if (v && p >= 1 && p <= 9) ok = (m_cell[p] == 0);
                m_err = v && !ok;
                if (ok) begin
                    m_cell[p] = m_player; m_phase = 2;
                end else if (m_timer == 0) begin
                    for (int k = 9; k >= 1; k--) if (m_cell[k] == 0) w = k;
                    m_cell[w] = m_player; m_to = 1; m_phase = 2;
                end else begin
                    m_timer--;
                end
            end else begin
                w = 0; full = 1;
                for (int l = 0; l < 8; l++)
                    if (m_cell[lines[l][0]] != 0 && m_cell[lines[l][0]] == m_cell[lines[l][1]]
                        && m_cell[lines[l][0]] == m_cell[lines[l][2]]) w = m_cell[lines[l][0]];
                for (int k = 1; k <= 9; k++) if (m_cell[k] == 0) full = 0;
                if (w != 0 || full) begin
                    m_over = 1; m_win = w; m_draw = (w == 0); m_phase = 3;
                end else begin
                    m_player = 3 - m_player; m_timer = TT - 1; m_phase = 1;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [17:0] eb;
        eb = '0;
        for (int k = 1; k <= 9; k++) eb = eb | (18'(m_cell[k]) << (2 * (k - 1)));
        chk("board", 32'(board), 32'(eb));
        chk("turn", 32'(turn), (m_phase == 1 || m_phase == 2) ? m_player : 0);
        chk("timer", 32'(timer), m_timer);
        chk("move_ready", 32'(move_ready), 32'(m_phase == 1));
        chk("move_err", 32'(move_err), 32'(m_err));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("game_over", 32'(game_over), 32'(m_over));
        chk("winner", 32'(winner), m_win);
        chk("draw", 32'(draw), 32'(m_draw));
    endtask

    task automatic step(input bit r, input bit s, input bit v, input int p);
        rst = r; start = s; move_valid = v; move_pos = 4'(p);
        @(posedge clk);
        model_edge(r, s, v, p);
        #1;
        check_model();
    endtask

    // Offer a move for one cycle, then let the judging cycle complete.
    task automatic play(input int p);
        step(1'b0, 1'b0, 1'b1, p);
        step(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        int pp;
        bit rr, ss, vv;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 0);
        chk("rst_board", 32'(board), 32'd0);
        chk("rst_ready", 32'(move_ready), 32'd0);

        // Player 1 wins on the top row
        step(1'b0, 1'b1, 1'b0, 0);
        chk("start_turn", 32'(turn), 32'd1);
        play(1); play(4); play(2); play(5); play(3);
        chk("win_over", 32'(game_over), 32'd1);
        chk("win_winner", 32'(winner), 32'd1);
        chk("win_row", 32'(board[5:0]), 32'b010101);
        chk("win_draw", 32'(draw), 32'd0);
        chk("win_ready", 32'(move_ready), 32'd0);

        // Restart from GAME_OVER, then illegal moves
        step(1'b0, 1'b1, 1'b0, 0);
        chk("restart_board", 32'(board), 32'd0);
        chk("restart_turn", 32'(turn), 32'd1);
        play(5);
        step(1'b0, 1'b0, 1'b1, 5);
        chk("err_occupied", 32'(move_err), 32'd1);
        step(1'b0, 1'b0, 1'b1, 0);
        chk("err_pos0", 32'(move_err), 32'd1);
        step(1'b0, 1'b0, 1'b1, 12);
        chk("err_pos12", 32'(move_err), 32'd1);
        chk("err_board", 32'(board), 32'h00100);
        chk("err_turn", 32'(turn), 32'd2);
        step(1'b0, 1'b1, 1'b0, 0);
        chk("start_ignored", 32'(board), 32'h00100);
        play(9);
        chk("p2_cell9", 32'(board[17:16]), 32'd2);
        chk("p2_turn_back", 32'(turn), 32'd1);

        // Mid-game reset aborts the game
        step(1'b1, 1'b0, 1'b0, 0);
        chk("abort_board", 32'(board), 32'd0);
        chk("abort_ready", 32'(move_ready), 32'd0);
        chk("abort_turn", 32'(turn), 32'd0);

        // Timeouts place marks in the lowest empty cells
        step(1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < TT; i++) step(1'b0, 1'b0, 1'b0, 0);
        chk("to1_cell1", 32'(board[1:0]), 32'd1);
        chk("to1_pulse", 32'(timeout), 32'd1);
        step(1'b0, 1'b0, 1'b0, 0);
        chk("to_pulse_clear", 32'(timeout), 32'd0);
        for (int i = 0; i < TT; i++) step(1'b0, 1'b0, 1'b0, 0);
        chk("to2_cell2", 32'(board[3:2]), 32'd2);
        chk("to2_pulse", 32'(timeout), 32'd1);

        // Draw game
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        play(1); play(2); play(3); play(5); play(4); play(6); play(8); play(7); play(9);
        chk("draw_flag", 32'(draw), 32'd1);
        chk("draw_winner", 32'(winner), 32'd0);
        chk("draw_over", 32'(game_over), 32'd1);

`ifdef TTT_SCORE_EN
        // Score saturation and reset
        step(1'b1, 1'b0, 1'b0, 0);
        for (int g = 0; g < 16; g++) begin
            step(1'b0, 1'b1, 1'b0, 0);
            play(1); play(4); play(2); play(5); play(3);
        end
        chk("score_p1_sat", 32'(score_p1), 32'd15);
        chk("score_p2", 32'(score_p2), 32'd0);
        chk("score_draw", 32'(score_draw), 32'd0);
        step(1'b1, 1'b0, 1'b0, 0);
        chk("score_p1_rst", 32'(score_p1), 32'd0);
`endif

        // Randomized play against the model
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 299) == 0);
            ss = ($urandom_range(0, 9) == 0);
            vv = ($urandom_range(0, 2) == 0);
            pp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                             : int'($urandom_range(1, 9));
            step(rr, ss, vv, pp);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
